g2_chain_search_ctrl: RTL and testbench
=======================================

// Module: g2_chain_search_ctrl
// PURPOSE
// Sequences one G2 table instance: walks a linked chain of G2 entries (head index -> next_index ...) for a
// 104-bit tuple until a rule matches, the chain ends or a hop limit is hit. Arbitrates the table's single
// index port between lookups and rule updates (entry writes). Sits between the subset dispatcher and one G2 table.
// PARAMETERS
// IDX_W     11     width of entry index / ruleID
// TUPLE_W   104    tuple width (srcIP,dstIP,srcPort,dstPort,proto)
// ENTRY_W   171    G2 entry width
// MAX_HOPS  19     max probes per lookup (= table depth)
// HOP_W     5      width of hop counter; must hold MAX_HOPS
// NULL_IDX  2047   next_index value terminating a chain
// PORTS
// clk              in   1        clock
// rst              in   1        async active-high reset
// req_valid        in   1        lookup request
// req_ready        out  1        lookup accepted when valid&ready
// req_head         in   IDX_W    first entry of chain
// req_tuple        in   TUPLE_W  packet tuple
// upd_valid        in   1        entry write request
// upd_ready        out  1        write accepted when valid&ready
// upd_addr         in   IDX_W    entry to write
// upd_data         in   ENTRY_W  new entry contents
// res_valid        out  1        lookup result available
// res_ready        in   1        consumer takes result
// res_match        out  1        1 = rule found
// res_ruleID       out  IDX_W    matched rule (0 on miss)
// res_hops         out  HOP_W    probes issued for this lookup
// tbl_search_index out  IDX_W    table index (registered)
// tbl_tupleData    out  TUPLE_W  tuple to table (registered)
// tbl_we           out  1        table write strobe
// tbl_din          out  ENTRY_W  table write data
// tbl_match        in   1        table compare result, valid 1 cycle after index
// tbl_ruleID       in   IDX_W    table ruleID, same timing
// tbl_next_index   in   IDX_W    table chain pointer, same timing
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 (req_ready, upd_ready, res_valid, tbl_we, indices, data, counters).
// - States IDLE, WRITE, PROBE, CHECK, DONE. req_ready = upd_ready = 0 outside IDLE.
// - IDLE: upd_valid has priority -> upd_ready=1, req_ready=0; handshake -> WRITE. Else req_ready=1;
//   handshake latches head/tuple, hops=0 -> PROBE, or directly DONE (miss, hops=0) if req_head==NULL_IDX.
// - WRITE: exactly one cycle tbl_we=1, tbl_search_index=upd_addr, tbl_din=upd_data; table outputs ignored; -> IDLE.
// - PROBE: drive tbl_search_index=cur_idx, tbl_tupleData=tuple; hops+=1; -> CHECK.
// - CHECK (table outputs valid): tbl_match -> DONE hit, ruleID=tbl_ruleID; else tbl_next_index==NULL_IDX
//   or hops==MAX_HOPS -> DONE miss; else cur_idx=tbl_next_index -> PROBE. Each hop costs 2 cycles.
// - DONE: res_valid=1, res_* stable until res_ready; on handshake -> IDLE, res_valid=0 next cycle.
// - tbl_match is sampled only in CHECK; stale values outside CHECK are ignored.
// - Latency from req handshake to res_valid = 2*hops + 1 cycles (1 cycle for NULL head).
// - One lookup in flight; updates wait until lookup result is consumed (no write mid-chain).
// - rst mid-lookup aborts silently; no res_valid produced; tbl_we deasserts immediately.
// CONFIGURATION
// - G2_CHAIN_STATS_EN defined: adds outputs stat_lookups[31:0], stat_hits[31:0] (increment on res
//   handshake, wrap at 2^32) and stat_max_hops[HOP_W-1:0] (running max of res_hops); all reset to 0.
// - Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - Head=3, entry3 matches ruleID 42 -> res_valid 3 cycles after accept, match=1, ruleID=42, hops=1.
// - Chain 3->7->NULL, no match -> miss, ruleID=0, hops=2, res_valid 5 cycles after accept.
// - Cyclic chain 5->5, no match -> terminates at hops=19, miss.
// - req_valid and upd_valid same cycle in IDLE -> write first (one tbl_we pulse), lookup accepted 1 cycle later and sees new data.
// - res_ready held low 10 cycles -> res_* stable, req_ready=upd_ready=0 throughout.
// - rst asserted during CHECK -> next cycle all outputs 0, state IDLE, no result emitted.

Source files
------------

// File: rtl/g2_chain_search_ctrl.sv
// g2_chain_search_ctrl
//
// Sequences one G2 table instance. A lookup walks the linked chain of G2
// entries starting at req_head (head -> next_index -> ...) for one 104-bit
// tuple. The walk stops when a rule matches, when the chain ends at NULL_IDX,
// or when MAX_HOPS probes have been issued. The table has a single index
// port, which this block shares between lookups and rule updates (entry
// writes).
//
// Handshakes: every channel (req, upd, res) transfers on a rising clk edge
// where valid and ready are both high. The producer holds valid and its
// payload steady until that edge. The controller only raises req_ready or
// upd_ready while idle, and never both in the same cycle. res_* stays frozen
// from the rise of res_valid until its transfer.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/ready/head/tuple   lookup request channel
//   upd_valid/ready/addr/data    entry-write request channel
//   res_valid/ready/match/ruleID/hops  lookup result channel
//   tbl_search_index, tbl_tupleData    registered index and tuple to the table
//   tbl_we, tbl_din                    registered write strobe and data
//   tbl_match, tbl_ruleID, tbl_next_index
//                            table read results, valid one cycle after the
//                            index was presented
//
// Optional feature: define G2_CHAIN_STATS_EN to add the lookup statistics
// outputs stat_lookups, stat_hits and stat_max_hops.

module g2_chain_search_ctrl #(
    parameter int IDX_W    = 11,
    parameter int TUPLE_W  = 104,
    parameter int ENTRY_W  = 171,
    parameter int MAX_HOPS = 19,
    parameter int HOP_W    = 5,
    parameter int NULL_IDX = 2047
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [IDX_W-1:0]   req_head,
    input  logic [TUPLE_W-1:0] req_tuple,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [IDX_W-1:0]   upd_addr,
    input  logic [ENTRY_W-1:0] upd_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_match,
    output logic [IDX_W-1:0]   res_ruleID,
    output logic [HOP_W-1:0]   res_hops,
    output logic [IDX_W-1:0]   tbl_search_index,
    output logic [TUPLE_W-1:0] tbl_tupleData,
    output logic               tbl_we,
    output logic [ENTRY_W-1:0] tbl_din,
    input  logic               tbl_match,
    input  logic [IDX_W-1:0]   tbl_ruleID,
    input  logic [IDX_W-1:0]   tbl_next_index
`ifdef G2_CHAIN_STATS_EN
    ,
    output logic [31:0]        stat_lookups,
    output logic [31:0]        stat_hits,
    output logic [HOP_W-1:0]   stat_max_hops
`endif
);

    localparam logic [IDX_W-1:0] NULL_I = IDX_W'(NULL_IDX);
    localparam logic [HOP_W-1:0] MAX_H  = HOP_W'(MAX_HOPS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_PROBE = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [HOP_W-1:0]   hops_q, hops_d;
    logic [IDX_W-1:0]   tbl_idx_q, tbl_idx_d;
    logic [TUPLE_W-1:0] tuple_q, tuple_d;
    logic               tbl_we_q, tbl_we_d;
    logic [ENTRY_W-1:0] tbl_din_q, tbl_din_d;
    logic               res_match_q, res_match_d;
    logic [IDX_W-1:0]   res_rule_q, res_rule_d;

    // The ready outputs are decoded from the state. They are also gated by
    // rst so that every output reads 0 while reset is held, even though the
    // reset state is IDLE.
    logic idle_open;
    assign idle_open = (state_q == S_IDLE) && !rst;

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        hops_d      = hops_q;
        tbl_idx_d   = tbl_idx_q;
        tuple_d     = tuple_q;
        tbl_we_d    = 1'b0;
        tbl_din_d   = tbl_din_q;
        res_match_d = res_match_q;
        res_rule_d  = res_rule_q;
        req_ready   = 1'b0;
        upd_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (idle_open) begin
                    if (upd_valid) begin
                        // Updates win over lookups. The write is registered,
                        // so the strobe is visible during WRITE.
                        upd_ready = 1'b1;
                        state_d   = S_WRITE;
                        tbl_we_d  = 1'b1;
                        tbl_idx_d = upd_addr;
                        tbl_din_d = upd_data;
                    end else begin
                        req_ready = 1'b1;
                        if (req_valid) begin
                            tuple_d     = req_tuple;
                            hops_d      = '0;
                            res_match_d = 1'b0;
                            res_rule_d  = '0;
                            if (req_head == NULL_I) begin
                                state_d = S_DONE;
                            end else begin
                                // The index is loaded now, so the table sees
                                // it during PROBE and answers in CHECK.
                                cur_idx_d = req_head;
                                tbl_idx_d = req_head;
                                state_d   = S_PROBE;
                            end
                        end
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_PROBE: begin
                tbl_idx_d = cur_idx_q;
                hops_d    = hops_q + HOP_W'(1);
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (tbl_match) begin
                    res_match_d = 1'b1;
                    res_rule_d  = tbl_ruleID;
                    state_d     = S_DONE;
                end else if ((tbl_next_index == NULL_I) || (hops_q == MAX_H)) begin
                    state_d = S_DONE;
                end else begin
                    cur_idx_d = tbl_next_index;
                    tbl_idx_d = tbl_next_index;
                    state_d   = S_PROBE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_idx_q   <= '0;
            hops_q      <= '0;
            tbl_idx_q   <= '0;
            tuple_q     <= '0;
            tbl_we_q    <= 1'b0;
            tbl_din_q   <= '0;
            res_match_q <= 1'b0;
            res_rule_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            hops_q      <= hops_d;
            tbl_idx_q   <= tbl_idx_d;
            tuple_q     <= tuple_d;
            tbl_we_q    <= tbl_we_d;
            tbl_din_q   <= tbl_din_d;
            res_match_q <= res_match_d;
            res_rule_q  <= res_rule_d;
        end
    end

    assign res_valid        = (state_q == S_DONE);
    assign res_match        = res_match_q;
    assign res_ruleID       = res_rule_q;
    assign res_hops         = hops_q;
    assign tbl_search_index = tbl_idx_q;
    assign tbl_tupleData    = tuple_q;
    assign tbl_we           = tbl_we_q;
    assign tbl_din          = tbl_din_q;

`ifdef G2_CHAIN_STATS_EN
    logic [31:0]      lookups_q, lookups_d;
    logic [31:0]      hits_q, hits_d;
    logic [HOP_W-1:0] max_hops_q, max_hops_d;
    logic             res_xfer;

    assign res_xfer = (state_q == S_DONE) && res_ready;

    always_comb begin
        lookups_d  = lookups_q;
        hits_d     = hits_q;
        max_hops_d = max_hops_q;
        if (res_xfer) begin
            // Both counters wrap naturally at 2^32.
            lookups_d = lookups_q + 32'd1;
            hits_d    = hits_q + {31'd0, res_match_q};
            if (hops_q > max_hops_q) begin
                max_hops_d = hops_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q  <= '0;
            hits_q     <= '0;
            max_hops_q <= '0;
        end else begin
            lookups_q  <= lookups_d;
            hits_q     <= hits_d;
            max_hops_q <= max_hops_d;
        end
    end

    assign stat_lookups  = lookups_q;
    assign stat_hits     = hits_q;
    assign stat_max_hops = max_hops_q;
`endif

endmodule

// File: tb/tb_g2_chain_search_ctrl.sv
// Testbench for g2_chain_search_ctrl.
//
// The G2 table is modelled behaviourally, with an entry layout local to this
// bench: {pad, valid, next_index, ruleID, tuple}. The model reads one cycle
// after the index is presented and writes on tbl_we. Expected lookup results
// are pushed into a scoreboard queue when a request is driven. They come
// either from constants or from a chain walk over a shadow copy of
// everything written. They are popped when res_valid rises.

module tb_g2_chain_search_ctrl;
    localparam int IDX_W    = 11;
    localparam int TUPLE_W  = 104;
    localparam int ENTRY_W  = 171;
    localparam int MAX_HOPS = 19;
    localparam int HOP_W    = 5;
    localparam int RW       = 1 + IDX_W + HOP_W;
    localparam logic [IDX_W-1:0] NULL_I = 11'd2047;

    localparam logic [TUPLE_W-1:0] T1 = 104'hC0A80001_0A000001_1F90_0050_06;
    localparam logic [TUPLE_W-1:0] T2 = 104'hC0A80002_0A000002_0035_0035_11;
    localparam logic [TUPLE_W-1:0] T3 = 104'h01020304_05060708_1234_5678_06;
    localparam logic [TUPLE_W-1:0] T4 = 104'hDEADBEEF_CAFEF00D_0001_0002_01;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [IDX_W-1:0]   req_head;
    logic [TUPLE_W-1:0] req_tuple;
    logic               upd_valid;
    logic               upd_ready;
    logic [IDX_W-1:0]   upd_addr;
    logic [ENTRY_W-1:0] upd_data;
    logic               res_valid;
    logic               res_ready;
    logic               res_match;
    logic [IDX_W-1:0]   res_ruleID;
    logic [HOP_W-1:0]   res_hops;
    logic [IDX_W-1:0]   tbl_search_index;
    logic [TUPLE_W-1:0] tbl_tupleData;
    logic               tbl_we;
    logic [ENTRY_W-1:0] tbl_din;
    logic               tbl_match;
    logic [IDX_W-1:0]   tbl_ruleID;
    logic [IDX_W-1:0]   tbl_next_index;
`ifdef G2_CHAIN_STATS_EN
    logic [31:0]        stat_lookups;
    logic [31:0]        stat_hits;
    logic [HOP_W-1:0]   stat_max_hops;
`endif

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [RW-1:0]      exp_q[$];
    logic [ENTRY_W-1:0] sh_mem [0:2047];

    g2_chain_search_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_head         (req_head),
        .req_tuple        (req_tuple),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .upd_addr         (upd_addr),
        .upd_data         (upd_data),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_match        (res_match),
        .res_ruleID       (res_ruleID),
        .res_hops         (res_hops),
        .tbl_search_index (tbl_search_index),
        .tbl_tupleData    (tbl_tupleData),
        .tbl_we           (tbl_we),
        .tbl_din          (tbl_din),
        .tbl_match        (tbl_match),
        .tbl_ruleID       (tbl_ruleID),
        .tbl_next_index   (tbl_next_index)
`ifdef G2_CHAIN_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_hits        (stat_hits),
        .stat_max_hops    (stat_max_hops)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- table model ----------------
    logic [ENTRY_W-1:0] tmem [0:2047];
    logic [ENTRY_W-1:0] rd_q;
    logic [TUPLE_W-1:0] key_q;

    always @(posedge clk) begin
        if (tbl_we) begin
            tmem[tbl_search_index] <= tbl_din;
        end else begin
            rd_q  <= tmem[tbl_search_index];
            key_q <= tbl_tupleData;
        end
    end

    assign tbl_match      = rd_q[126] && (rd_q[103:0] == key_q);
    assign tbl_ruleID     = rd_q[114:104];
    assign tbl_next_index = rd_q[125:115];

    always @(posedge clk) begin
        if (tbl_we) we_cnt <= we_cnt + 1;
    end

    function automatic logic [ENTRY_W-1:0] mk_entry(input logic v, input logic [TUPLE_W-1:0] t,
                                                    input logic [IDX_W-1:0] rule,
                                                    input logic [IDX_W-1:0] nxt);
        return {44'd0, v, nxt, rule, t};
    endfunction

    // Reference chain walk over the shadow copy of written entries.
    function automatic logic [RW-1:0] model_lookup(input logic [IDX_W-1:0] head,
                                                   input logic [TUPLE_W-1:0] tup);
        logic [IDX_W-1:0]   idx;
        logic [ENTRY_W-1:0] e;
        logic [HOP_W-1:0]   h;
        idx = head;
        h   = '0;
        if (head == NULL_I) return {1'b0, {IDX_W{1'b0}}, h};
        for (int i = 0; i < MAX_HOPS; i++) begin
            e = sh_mem[idx];
            h = h + 5'd1;
            if (e[126] && (e[103:0] == tup)) return {1'b1, e[114:104], h};
            if (e[125:115] == NULL_I) return {1'b0, {IDX_W{1'b0}}, h};
            idx = e[125:115];
        end
        return {1'b0, {IDX_W{1'b0}}, h};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_write(input logic [IDX_W-1:0] addr, input logic [ENTRY_W-1:0] data);
        int w;
        @(negedge clk);
        upd_valid = 1'b1;
        upd_addr  = addr;
        upd_data  = data;
        #1;
        w = 0;
        while (!upd_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("FAIL write_timeout addr=%0d got no upd_ready", addr);
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        sh_mem[addr] = data;
    endtask

    // Issues one lookup and returns at the negedge where res_valid is seen.
    // lat counts cycles from the handshake cycle (cycle 0).
    task automatic run_lookup(input logic [IDX_W-1:0] head, input logic [TUPLE_W-1:0] tup,
                              output logic [RW-1:0] obs, output int lat);
        int w;
        @(negedge clk);
        req_valid = 1'b1;
        req_head  = head;
        req_tuple = tup;
        #1;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("FAIL req_timeout head=%0d got no req_ready", head);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid && lat < 200);
        obs = {res_match, res_ruleID, res_hops};
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    // Scoreboard: pops the oldest expectation and compares result and latency.
    task automatic sb_check(input string name, input logic [RW-1:0] obs, input int lat);
        logic [RW-1:0]    e;
        logic [HOP_W-1:0] eh;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s result with empty scoreboard got=%h", name, obs);
            return;
        end
        e  = exp_q.pop_front();
        eh = e[HOP_W-1:0];
        if (lat >= 200) begin
            errors++;
            $display("FAIL %s res_valid timeout", name);
        end else if (obs !== e) begin
            errors++;
            $display("FAIL %s result {match,rule,hops} got=%0d,%0d,%0d exp=%0d,%0d,%0d", name,
                     obs[RW-1], obs[RW-2:HOP_W], obs[HOP_W-1:0], e[RW-1], e[RW-2:HOP_W], eh);
        end
        checks++;
        if (lat !== 2 * int'(eh) + 1) begin
            errors++;
            $display("FAIL %s latency got=%0d exp=%0d", name, lat, 2 * int'(eh) + 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_head = '0; req_tuple = '0;
        upd_valid = 1'b0; upd_addr = '0; upd_data = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, upd_ready, res_valid, tbl_we, res_match} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {req_ready, upd_ready, res_valid, tbl_we, res_match});
        end
        checks++;
        if ({tbl_search_index, res_ruleID, res_hops} !== '0 || tbl_tupleData !== '0 || tbl_din !== '0) begin
            errors++;
            $display("FAIL reset_data idx=%0d rule=%0d hops=%0d (exp all 0)",
                     tbl_search_index, res_ruleID, res_hops);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || upd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_ready req=%b upd=%b exp req=1 upd=0", req_ready, upd_ready);
        end
    endtask

    task automatic test_single_hit();
        logic [RW-1:0] obs;
        int lat;
        drive_write(11'd3, mk_entry(1'b1, T1, 11'd42, NULL_I));
        exp_q.push_back({1'b1, 11'd42, 5'd1});
        run_lookup(11'd3, T1, obs, lat);
        sb_check("single_hit", obs, lat);
        accept_result();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hit_res_valid_drop got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_chain_miss();
        logic [RW-1:0] obs;
        int lat;
        drive_write(11'd3, mk_entry(1'b1, T1, 11'd42, 11'd7));
        drive_write(11'd7, mk_entry(1'b1, T2, 11'd99, NULL_I));
        exp_q.push_back({1'b0, 11'd0, 5'd2});
        run_lookup(11'd3, T3, obs, lat);
        sb_check("chain_miss", obs, lat);
        accept_result();
        exp_q.push_back({1'b1, 11'd99, 5'd2});
        run_lookup(11'd3, T2, obs, lat);
        sb_check("chain_hit2", obs, lat);
        accept_result();
    endtask

    task automatic test_null_head();
        logic [RW-1:0] obs;
        int lat;
        exp_q.push_back({1'b0, 11'd0, 5'd0});
        run_lookup(NULL_I, T1, obs, lat);
        sb_check("null_head", obs, lat);
        accept_result();
    endtask

    task automatic test_cyclic();
        logic [RW-1:0] obs;
        int lat;
        drive_write(11'd5, mk_entry(1'b1, T1, 11'd55, 11'd5));
        exp_q.push_back({1'b0, 11'd0, 5'd19});
        run_lookup(11'd5, T3, obs, lat);
        sb_check("cyclic_limit", obs, lat);
        accept_result();
    endtask

    task automatic test_collision();
        logic [ENTRY_W-1:0] d;
        logic [RW-1:0]      obs;
        int we0, lat;
        d   = mk_entry(1'b1, T4, 11'd77, NULL_I);
        we0 = we_cnt;
        @(negedge clk);
        upd_valid = 1'b1; upd_addr = 11'd9; upd_data = d;
        req_valid = 1'b1; req_head = 11'd9; req_tuple = T4;
        #1;
        checks++;
        if (upd_ready !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll_priority upd_ready=%b req_ready=%b exp 1,0", upd_ready, req_ready);
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        sh_mem[9] = d;
        exp_q.push_back(model_lookup(11'd9, T4));
        @(negedge clk);
        checks++;
        if (tbl_we !== 1'b1 || tbl_search_index !== 11'd9 || tbl_din !== d || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll_write we=%b idx=%0d din_ok=%b req_ready=%b exp 1,9,1,0",
                     tbl_we, tbl_search_index, tbl_din === d, req_ready);
        end
        @(negedge clk);
        checks++;
        if (tbl_we !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll_after_write we=%b req_ready=%b exp 0,1", tbl_we, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid && lat < 200);
        obs = {res_match, res_ruleID, res_hops};
        sb_check("coll_lookup_new_data", obs, lat);
        accept_result();
        checks++;
        if (we_cnt - we0 !== 1) begin
            errors++;
            $display("FAIL coll_we_pulses got=%0d exp=1", we_cnt - we0);
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] obs;
        logic [RW-1:0] e;
        int lat, bad_res, bad_rdy;
        e = model_lookup(11'd3, T1);
        exp_q.push_back(e);
        run_lookup(11'd3, T1, obs, lat);
        req_valid = 1'b1; req_head = 11'd7; req_tuple = T2;
        upd_valid = 1'b1; upd_addr = 11'($urandom_range(0, 2000)); upd_data = '1;
        bad_res = 0;
        bad_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({res_valid, res_match, res_ruleID, res_hops} !== {1'b1, e}) bad_res++;
            if (req_ready !== 1'b0 || upd_ready !== 1'b0 || tbl_we !== 1'b0) bad_rdy++;
        end
        checks++;
        if (bad_res != 0) begin
            errors++;
            $display("FAIL bp_res_stable unstable_cycles got=%0d exp=0", bad_res);
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL bp_ready_low ready_or_we_high_cycles got=%0d exp=0", bad_rdy);
        end
        req_valid = 1'b0;
        upd_valid = 1'b0;
        sb_check("bp_result", obs, lat);
        accept_result();
    endtask

    task automatic test_reset_mid();
        int we0, seen;
        we0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_head = 11'd5; req_tuple = T3;
        #1;
        seen = 0;
        while (!req_ready && seen < 100) begin
            @(negedge clk);
            #1;
            seen++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);             // PROBE
        @(negedge clk);             // CHECK
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, upd_ready, res_valid, tbl_we, res_match} !== 5'b0 ||
            tbl_search_index !== '0 || tbl_tupleData !== '0 || tbl_din !== '0 || res_hops !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs flags=%b idx=%0d hops=%0d exp all 0",
                     {req_ready, upd_ready, res_valid, tbl_we, res_match}, tbl_search_index, res_hops);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        checks++;
        if (seen != 0 || we_cnt != we0) begin
            errors++;
            $display("FAIL rstmid_no_result res_valid_cycles=%0d we_pulses=%0d exp 0,0", seen, we_cnt - we0);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle req_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [IDX_W-1:0]   heads [6];
        logic [TUPLE_W-1:0] tups  [4];
        logic [IDX_W-1:0]   h;
        logic [TUPLE_W-1:0] t;
        logic [RW-1:0]      obs;
        int lat;
        heads = '{11'd3, 11'd5, 11'd7, 11'd9, 11'd12, 11'd2047};
        tups  = '{T1, T2, T3, T4};
        drive_write(11'd12, mk_entry(1'b1, T2, 11'd300, 11'd3));
        for (int i = 0; i < 12; i++) begin
            h = heads[$urandom_range(0, 5)];
            t = tups[$urandom_range(0, 3)];
            exp_q.push_back(model_lookup(h, t));
            run_lookup(h, t, obs, lat);
            sb_check("b2b", obs, lat);
            accept_result();
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_chain_miss();
        test_null_head();
        test_cyclic();
        test_collision();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
